// File: rtl/cache_bus_pkg.sv
// Shared definitions for the data-cache line bus and its memory-side bridge.
// Line geometry (128-bit line, four 32-bit words) and the bridge FSM encoding.
package cache_bus_pkg;

    localparam int unsigned LINE_W   = 128;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned BEATS    = 4;
    localparam int unsigned OFFSET_W = 4;
    // Width of a line address (byte address with the in-line offset dropped)
    localparam int unsigned LADDR_W  = 32 - OFFSET_W;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWr      = 2'd1,
        StRdIssue = 2'd2,
        StRdWait  = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/bridge_rd_pipe.sv
// Read-return tracker for dcache_mem_bridge.
// An RD_LAT-deep valid shift register tags every granted read issue; when a tag
// reaches the end, the SRAM word on mem_rdata belongs to the current line and is
// stored into the slot given by a 2-bit return counter.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   issue      a read beat was granted this cycle
//   cap_en     mem_rdata holds a returned word this cycle
//   cap_slot   line slot (word index) for that word
//   cap_last   the returned word is the last of the line
module bridge_rd_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue,
    output logic       cap_en,
    output logic [1:0] cap_slot,
    output logic       cap_last
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [1:0]        slot_q, slot_d;

    assign cap_en   = vld_q[RD_LAT-1];
    assign cap_slot = slot_q;
    assign cap_last = cap_en & (slot_q == 2'd3);

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = issue;
        slot_d   = cap_en ? slot_q + 2'd1 : slot_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            slot_q <= '0;
        end else begin
            vld_q  <= vld_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/dcache_mem_bridge.sv
// Memory-side responder for the data-cache line bus.
// Serves 128-bit line write-backs and refills as four 32-bit beats on a
// synchronous SRAM port behind the memory arbiter (an access counts only on
// mem_ce & mem_gnt).
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   cpu_wen/cpu_waddr/cpu_wdata      write-back request (wen = byte enables)
//   dev_wrdy                         write-back can be accepted
//   cpu_ren/cpu_raddr                refill request
//   dev_rrdy                         refill can be accepted
//   dev_rvalid/dev_rdata             one-cycle refill completion with the line
//   mem_ce/mem_we/mem_be/mem_addr/mem_wdata/mem_rdata/mem_gnt   SRAM port
// Build option: DCACHE_BRIDGE_WBUF_EN adds a one-entry line write buffer.
// Write-backs are latched in one cycle, refills hitting the buffered line are
// answered from it, and the buffer drains to SRAM whenever the bridge is idle.
module dcache_mem_bridge
    import cache_bus_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned MEM_AW = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cpu_wen,
    input  logic [31:0]       cpu_waddr,
    input  logic [LINE_W-1:0] cpu_wdata,
    output logic              dev_wrdy,
    input  logic [3:0]        cpu_ren,
    input  logic [31:0]       cpu_raddr,
    output logic              dev_rrdy,
    output logic              dev_rvalid,
    output logic [LINE_W-1:0] dev_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_gnt
);

    bridge_state_e      state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic [LADDR_W-1:0] wr_line_q, rd_line_q, cur_line;
    logic [LINE_W-1:0]  wr_data_q, rbuf_q, rdata_q;
    logic [3:0]         wr_be_q;
    logic               rvalid_q, rvalid_d;
    logic               wr_acc, rd_acc, issue, last_beat;
    logic               cap_en, cap_last;
    logic [1:0]         cap_slot;

`ifdef DCACHE_BRIDGE_WBUF_EN
    logic wbuf_vld_q, wbuf_vld_d;
    logic hit_q, hit_d;
    logic rd_hit;

    // The write latch doubles as the buffer; it is free whenever not valid.
    assign dev_wrdy = ~wbuf_vld_q;
`else
    assign dev_wrdy = (state_q == StIdle);
`endif
    assign dev_rrdy   = (state_q == StIdle);
    assign wr_acc     = (|cpu_wen) & dev_wrdy;
    // A write arriving together with a read wins; the read is dropped.
    assign rd_acc     = (|cpu_ren) & dev_rrdy & ~wr_acc;
    assign issue      = mem_ce & mem_gnt;
    assign last_beat  = issue & (beat_q == 2'd3);
    // Counter wraps 3->0 only when the last beat is granted.
    assign beat_d     = issue ? beat_q + 2'd1 : beat_q;
    assign dev_rvalid = rvalid_q;
    assign dev_rdata  = rdata_q;

    bridge_rd_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .issue   (issue & ~mem_we),
        .cap_en  (cap_en),
        .cap_slot(cap_slot),
        .cap_last(cap_last)
    );

    // SRAM port, decoded straight from the state so reset drops mem_ce at once.
    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        cur_line  = (state_q == StWr) ? wr_line_q : rd_line_q;
        if (state_q == StWr || state_q == StRdIssue) begin
            mem_ce   = 1'b1;
            mem_addr = {cur_line[MEM_AW-3:0], beat_q};
            if (state_q == StWr) begin
                mem_we    = 1'b1;
                mem_be    = wr_be_q;
                mem_wdata = wr_data_q[{beat_q, 5'd0} +: WORD_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rvalid_d = cap_last;
`ifdef DCACHE_BRIDGE_WBUF_EN
        hit_d      = 1'b0;
        wbuf_vld_d = wbuf_vld_q;
        rd_hit     = wbuf_vld_q & (cpu_raddr[31:OFFSET_W] == wr_line_q);
        if (hit_q) begin
            rvalid_d = 1'b1;
        end
        if (wr_acc) begin
            wbuf_vld_d = 1'b1;
        end else if (state_q == StWr && last_beat) begin
            wbuf_vld_d = 1'b0;
        end
`endif
        unique case (state_q)
            StIdle: begin
`ifdef DCACHE_BRIDGE_WBUF_EN
                // Refills go ahead of a pending drain.
                if (rd_acc) begin
                    hit_d   = rd_hit;
                    state_d = rd_hit ? StRdWait : StRdIssue;
                end else if (wbuf_vld_q) begin
                    state_d = StWr;
                end
`else
                if (wr_acc) begin
                    state_d = StWr;
                end else if (rd_acc) begin
                    state_d = StRdIssue;
                end
`endif
            end
            StWr: begin
                if (last_beat) state_d = StIdle;
            end
            StRdIssue: begin
                if (last_beat) state_d = StRdWait;
            end
            StRdWait: begin
                // Leave in the same cycle the completion pulse is shown.
                if (rvalid_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            beat_q    <= 2'd0;
            wr_line_q <= '0;
            wr_data_q <= '0;
            wr_be_q   <= 4'h0;
            rd_line_q <= '0;
            rbuf_q    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
`ifdef DCACHE_BRIDGE_WBUF_EN
            wbuf_vld_q <= 1'b0;
            hit_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            rvalid_q <= rvalid_d;
            if (wr_acc) begin
                wr_line_q <= cpu_waddr[31:OFFSET_W];
                wr_data_q <= cpu_wdata;
                wr_be_q   <= cpu_wen;
            end
            if (rd_acc) begin
                rd_line_q <= cpu_raddr[31:OFFSET_W];
            end
            if (cap_en) begin
                rbuf_q[{cap_slot, 5'd0} +: WORD_W] <= mem_rdata;
            end
            // Publish the line only when complete so dev_rdata holds the last refill.
            if (cap_last) begin
                rdata_q <= {mem_rdata, rbuf_q[3*WORD_W-1:0]};
            end
`ifdef DCACHE_BRIDGE_WBUF_EN
            wbuf_vld_q <= wbuf_vld_d;
            hit_q      <= hit_d;
            if (hit_q) begin
                rdata_q <= wr_data_q;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Directed bench for dcache_mem_bridge (RD_LAT=2, MEM_AW=20) with a small
// SRAM + arbiter model. Build with DCACHE_BRIDGE_WBUF_EN to run the buffer tests.
module tb_dcache_mem_bridge;

    logic         clk;
    logic         rst;
    logic [3:0]   cpu_wen;
    logic [31:0]  cpu_waddr;
    logic [127:0] cpu_wdata;
    logic         dev_wrdy;
    logic [3:0]   cpu_ren;
    logic [31:0]  cpu_raddr;
    logic         dev_rrdy;
    logic         dev_rvalid;
    logic [127:0] dev_rdata;
    logic         mem_ce;
    logic         mem_we;
    logic [3:0]   mem_be;
    logic [19:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_gnt;

    int errors = 0;
    int checks = 0;

    dcache_mem_bridge #(
        .RD_LAT(2),
        .MEM_AW(20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_wen   (cpu_wen),
        .cpu_waddr (cpu_waddr),
        .cpu_wdata (cpu_wdata),
        .dev_wrdy  (dev_wrdy),
        .cpu_ren   (cpu_ren),
        .cpu_raddr (cpu_raddr),
        .dev_rrdy  (dev_rrdy),
        .dev_rvalid(dev_rvalid),
        .dev_rdata (dev_rdata),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_gnt   (mem_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: two-cycle read latency; ungranted slots return a poison word.
    logic [31:0] sram [0:4095];
    logic [31:0] rd_p1;
    logic [20:0] acc_log [0:63];
    int          acc_n = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_p1         <= 32'h0;
            mem_rdata     <= 32'h0;
            sram[12'h800] <= 32'd1;
            sram[12'h801] <= 32'd2;
            sram[12'h802] <= 32'd3;
            sram[12'h803] <= 32'd4;
        end else begin
            if (mem_ce && mem_gnt) begin
                if (acc_n < 64) acc_log[acc_n] <= {mem_we, mem_addr};
                acc_n <= acc_n + 1;
                if (mem_we) begin
                    for (int i = 0; i < 4; i++) begin
                        if (mem_be[i]) sram[mem_addr[11:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
                    end
                end
            end
            rd_p1     <= (mem_ce && mem_gnt && !mem_we) ? sram[mem_addr[11:0]] : 32'hDEAD_BEEF;
            mem_rdata <= rd_p1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int          n;
    int          base;
    int          pulses;
    int          pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [31:0] wexp [4] = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        cpu_wen   = 4'h0;
        cpu_waddr = 32'h0;
        cpu_wdata = '0;
        cpu_ren   = 4'h0;
        cpu_raddr = 32'h0;
        mem_gnt   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wrdy", dev_wrdy, 1);
        check("rst_rrdy", dev_rrdy, 1);
        check("rst_rvalid", dev_rvalid, 0);
        check("rst_rdata", dev_rdata, 0);
        check("rst_ce", {mem_ce, mem_we, mem_be}, 0);
        check("rst_addr", {mem_addr, mem_wdata}, 0);
        rst = 1'b1;
        tick();

`ifdef DCACHE_BRIDGE_WBUF_EN
        // Write latched, then a refill of the same line is served from the buffer.
        cpu_wen   = 4'hF;
        cpu_waddr = 32'h0000_3000;
        cpu_wdata = 128'h3333_0004_3333_0003_3333_0002_3333_0001;
        check("wb_wrdy", dev_wrdy, 1);
        tick();
        cpu_wen   = 4'h0;
        check("wb_full", dev_wrdy, 0);
        cpu_ren   = 4'hF;
        cpu_raddr = 32'h0000_3004;
        check("wb_rrdy", dev_rrdy, 1);
        tick();
        cpu_ren = 4'h0;
        check("wb_hit_ce1", mem_ce, 0);
        check("wb_hit_early", dev_rvalid, 0);
        tick();
        check("wb_hit_ce2", mem_ce, 0);
        check("wb_hit_rvalid", dev_rvalid, 1);
        check("wb_hit_data", dev_rdata, 128'h3333_0004_3333_0003_3333_0002_3333_0001);
        n = 0;
        while (!dev_wrdy && n < 20) begin tick(); n++; end
        check("wb_drained", dev_wrdy, 1);
        check("wb_sram0", sram[12'hC00], 32'h3333_0001);
        check("wb_sram3", sram[12'hC03], 32'h3333_0004);

        // Refill of another line overtakes the pending drain.
        base      = acc_n;
        cpu_wen   = 4'hF;
        cpu_waddr = 32'h0000_3000;
        cpu_wdata = 128'h7777_0004_7777_0003_7777_0002_7777_0001;
        tick();
        cpu_wen   = 4'h0;
        cpu_ren   = 4'hF;
        cpu_raddr = 32'h0000_4000;
        tick();
        cpu_ren = 4'h0;
        n = 0;
        while (!dev_rvalid && n < 30) begin tick(); n++; end
        check("wb_miss_rvalid", dev_rvalid, 1);
        n = 0;
        while (!dev_wrdy && n < 30) begin tick(); n++; end
        check("wb_miss_drained", dev_wrdy, 1);
        check("wb_miss_count", acc_n - base, 8);
        for (int k = 0; k < 4; k++) begin
            check("wb_miss_rd_beat", acc_log[base+k], 21'h01000 + k);
            check("wb_miss_wr_beat", acc_log[base+4+k], 21'h100C00 + k);
        end
`else
        // Write-back with grant held high.
        cpu_wen   = 4'hF;
        cpu_waddr = 32'h0000_1234;
        cpu_wdata = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
        check("wr_accept_rdy", dev_wrdy, 1);
        tick();
        cpu_wen = 4'h0;
        for (int k = 0; k < 4; k++) begin
            check("wr_ce_we", {mem_ce, mem_we, mem_be}, 6'b11_1111);
            check("wr_addr", mem_addr, 32'h48C + k);
            check("wr_data", mem_wdata, wexp[k]);
            check("wr_rdy_low", {dev_wrdy, dev_rrdy}, 0);
            tick();
        end
        check("wr_done_rdy", dev_wrdy, 1);
        check("wr_done_ce", mem_ce, 0);
        check("wr_sram_first", sram[12'h48C], 32'hAAAA_AAAA);
        check("wr_sram_last", sram[12'h48F], 32'hDDDD_DDDD);

        // Refill, RD_LAT=2: completion 7 cycles after accept.
        cpu_ren   = 4'hF;
        cpu_raddr = 32'h0000_2000;
        tick();
        cpu_ren = 4'h0;
        n = 1;
        while (!dev_rvalid && n < 20) begin tick(); n++; end
        check("rd_latency", n, 7);
        check("rd_line", dev_rdata, 128'h4_0000_0003_0000_0002_0000_0001);
        tick();
        check("rd_pulse", dev_rvalid, 0);
        check("rd_hold", dev_rdata, 128'h4_0000_0003_0000_0002_0000_0001);
        check("rd_rrdy", dev_rrdy, 1);

        // Overwrite line 0x2000 so the next refill must return fresh words.
        cpu_wen   = 4'hF;
        cpu_waddr = 32'h0000_2000;
        cpu_wdata = 128'h5555_0003_5555_0002_5555_0001_5555_0000;
        tick();
        cpu_wen = 4'h0;
        repeat (4) tick();

        // Refill under grant stalls.
        base      = acc_n;
        pulses    = 0;
        cpu_ren   = 4'hF;
        cpu_raddr = 32'h0000_2000;
        tick();
        cpu_ren = 4'h0;
        for (int i = 0; i < 7; i++) begin
            mem_gnt = pat[i][0];
            tick();
            if (dev_rvalid) pulses++;
        end
        mem_gnt = 1'b1;
        n = 0;
        while (!dev_rvalid && n < 20) begin tick(); n++; end
        check("stall_early", pulses, 0);
        check("stall_rvalid", dev_rvalid, 1);
        check("stall_issues", acc_n - base, 4);
        for (int k = 0; k < 4; k++) begin
            check("stall_addr", acc_log[base+k], 21'h00800 + k);
        end
        check("stall_line", dev_rdata, 128'h5555_0003_5555_0002_5555_0001_5555_0000);
        tick();

        // Simultaneous write and read: write wins, read dropped.
        cpu_wen   = 4'hF;
        cpu_waddr = 32'h0000_5000;
        cpu_wdata = 128'h6666_0003_6666_0002_6666_0001_6666_0000;
        cpu_ren   = 4'hF;
        cpu_raddr = 32'h0000_2000;
        tick();
        cpu_wen = 4'h0;
        cpu_ren = 4'h0;
        check("sim_we", {mem_ce, mem_we}, 2'b11);
        check("sim_addr", mem_addr, 20'h01400);
        pulses = 0;
        repeat (10) begin
            if (dev_rvalid) pulses++;
            tick();
        end
        check("sim_no_rvalid", pulses, 0);
        check("sim_idle", {dev_wrdy, dev_rrdy}, 2'b11);
        cpu_ren   = 4'hF;
        cpu_raddr = 32'h0000_5000;
        tick();
        cpu_ren = 4'h0;
        n = 0;
        while (!dev_rvalid && n < 20) begin tick(); n++; end
        check("sim_readback", dev_rdata, 128'h6666_0003_6666_0002_6666_0001_6666_0000);
        tick();

        // Reset in the middle of a refill.
        cpu_ren   = 4'hF;
        cpu_raddr = 32'h0000_2000;
        tick();
        cpu_ren = 4'h0;
        tick();
        check("rstm_pre_ce", mem_ce, 1);
        #1 rst = 1'b0;
        #1;
        check("rstm_async_ce", mem_ce, 0);
        tick();
        tick();
        rst = 1'b1;
        check("rstm_rrdy", {dev_wrdy, dev_rrdy}, 2'b11);
        pulses = 0;
        repeat (10) begin
            tick();
            if (dev_rvalid) pulses++;
        end
        check("rstm_no_rvalid", pulses, 0);
        check("rstm_idle_ce", mem_ce, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
